// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS run controller and the datapath decoder.
// Holds:
//   - the command opcodes carried on CmdOp
//   - the controller state encoding shown on the State debug readout
//   - the HALT opcode, so the decoder that drives HaltDetected uses the same value
//   - the registered control-output bundle and its per-state decode
package mips_ctrl_pkg;

  localparam logic [1:0] CMD_RUN   = 2'd0;
  localparam logic [1:0] CMD_STEP  = 2'd1;
  localparam logic [1:0] CMD_STOP  = 2'd2;
  localparam logic [1:0] CMD_CLEAR = 2'd3;

  // Primary opcode field value that the decoder treats as HALT.
  localparam logic [5:0] HALT_OPCODE = 6'h3F;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  typedef struct packed {
    logic pipe_en;
    logic pc_hold;
    logic ifid_flush;
    logic cmd_ready;
  } ctrl_t;

  // Level outputs are a pure function of the state being entered. They are
  // loaded into a register together with the state, so they stay glitch-free.
  function automatic ctrl_t ctrl_of(state_e s);
    ctrl_t c;
    c.pipe_en    = (s == ST_RUN) || (s == ST_STEP) || (s == ST_DRAIN);
    c.pc_hold    = (s == ST_DRAIN);
    c.ifid_flush = (s == ST_DRAIN);
    c.cmd_ready  = (s == ST_IDLE) || (s == ST_RUN) || (s == ST_HALTED);
    return c;
  endfunction

endpackage

// File: rtl/mips_run_controller_if.sv
// Command channel between the debug/host side and the run controller.
// Signals:
//   CmdValid   host -> ctrl  command present
//   CmdReady   ctrl -> host  command can be accepted this cycle
//   CmdOp      host -> ctrl  RUN / STEP / STOP / CLEAR
//   StepCount  host -> ctrl  cycle count for STEP (0 means 1)
// Modports:
//   master  the host side
//   slave   the controller
interface mips_run_controller_if #(
  parameter int STEP_W = 16
);
  logic              CmdValid;
  logic              CmdReady;
  logic [1:0]        CmdOp;
  logic [STEP_W-1:0] StepCount;

  modport master (output CmdValid, output CmdOp, output StepCount, input CmdReady);
  modport slave  (input CmdValid, input CmdOp, input StepCount, output CmdReady);
endinterface

// File: rtl/mips_run_controller_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk    clock, rising edge
//   rst    synchronous active-high reset
//   en     count enable
//   clr    synchronous clear; wins over en
//   count  current value; sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mips_run_controller.sv
// Execution sequencer for the 5-stage MIPS pipeline.
// Turns RUN/STEP/STOP/CLEAR commands into the global pipeline enable, and
// drains the in-flight instructions after a HALT reaches IF/ID before
// freezing the pipeline.
// Ports:
//   ClockIn        system clock, rising edge
//   Reset          synchronous active-high reset
//   cmd            command channel (CmdValid/CmdReady/CmdOp/StepCount)
//   HaltDetected   IF/ID holds the HALT opcode
//   PipeEnable     enable for PC and all pipeline registers
//   PCHold         freeze PC while later stages advance
//   IFIDFlush      load a bubble into IF/ID
//   DatapathReset  one-cycle reset pulse to the datapath
//   CycleCount     saturating count of cycles with PipeEnable=1
//   Done           one-cycle pulse after a STEP or a drain completes
//   State          encoded state for debug readout
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | pipeline frozen, waiting for a command
// ST_RUN    | free-running until STOP or HALT
// ST_STEP   | running for a fixed number of cycles, commands blocked
// ST_DRAIN  | HALT in IF/ID; later stages finish, no new fetch
// ST_HALTED | frozen after a HALT; only CLEAR leaves
module mips_run_controller
  import mips_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int STEP_W       = 16,
  parameter int CNT_W        = 32
) (
  input  logic                    ClockIn,
  input  logic                    Reset,
  mips_run_controller_if.slave    cmd,
  input  logic                    HaltDetected,
  output logic                    PipeEnable,
  output logic                    PCHold,
  output logic                    IFIDFlush,
  output logic                    DatapathReset,
  output logic [CNT_W-1:0]        CycleCount,
  output logic                    Done,
  output logic [2:0]              State
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  state_e            state;
  ctrl_t             ctrl_q;
  logic [STEP_W-1:0] step_cnt;
  logic [DW-1:0]     drain_cnt;
  logic              cmd_fire;
  logic              halt_seen;
  logic              clear_fire;

  assign cmd_fire  = cmd.CmdValid & ctrl_q.cmd_ready;
  // HALT only matters while the pipeline is actually advancing under RUN/STEP;
  // in DRAIN the same instruction is still visible and must be ignored.
  assign halt_seen = HaltDetected & ctrl_q.pipe_en &
                     ((state == ST_RUN) || (state == ST_STEP));
  // CLEAR acts only from the frozen states; in RUN it is swallowed.
  assign clear_fire = cmd_fire && (cmd.CmdOp == CMD_CLEAR) &&
                      ((state == ST_IDLE) || (state == ST_HALTED));

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state         <= ST_IDLE;
      ctrl_q        <= ctrl_of(ST_IDLE);
      step_cnt      <= '0;
      drain_cnt     <= '0;
      Done          <= 1'b0;
      DatapathReset <= 1'b0;
    end else begin
      Done          <= 1'b0;
      DatapathReset <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            unique case (cmd.CmdOp)
              CMD_RUN: begin
                state  <= ST_RUN;
                ctrl_q <= ctrl_of(ST_RUN);
              end
              CMD_STEP: begin
                state    <= ST_STEP;
                ctrl_q   <= ctrl_of(ST_STEP);
                step_cnt <= (cmd.StepCount == '0) ? STEP_W'(1) : cmd.StepCount;
              end
              CMD_CLEAR: DatapathReset <= 1'b1;
              default: ;
            endcase
          end
        end

        ST_RUN: begin
          if (halt_seen) begin
            state     <= ST_DRAIN;
            ctrl_q    <= ctrl_of(ST_DRAIN);
            drain_cnt <= DW'(DRAIN_CYCLES);
          end else if (cmd_fire && (cmd.CmdOp == CMD_STOP)) begin
            state  <= ST_IDLE;
            ctrl_q <= ctrl_of(ST_IDLE);
          end
        end

        ST_STEP: begin
          if (halt_seen) begin
            // A HALT on the last step cycle cancels the step's Done.
            state     <= ST_DRAIN;
            ctrl_q    <= ctrl_of(ST_DRAIN);
            drain_cnt <= DW'(DRAIN_CYCLES);
          end else begin
            step_cnt <= step_cnt - STEP_W'(1);
            if (step_cnt == STEP_W'(1)) begin
              state  <= ST_IDLE;
              ctrl_q <= ctrl_of(ST_IDLE);
              Done   <= 1'b1;
            end
          end
        end

        ST_DRAIN: begin
          drain_cnt <= drain_cnt - DW'(1);
          if (drain_cnt == DW'(1)) begin
            state  <= ST_HALTED;
            ctrl_q <= ctrl_of(ST_HALTED);
            Done   <= 1'b1;
          end
        end

        ST_HALTED: begin
          if (clear_fire) begin
            state         <= ST_IDLE;
            ctrl_q        <= ctrl_of(ST_IDLE);
            DatapathReset <= 1'b1;
          end
        end

        default: begin
          state  <= ST_IDLE;
          ctrl_q <= ctrl_of(ST_IDLE);
        end
      endcase
    end
  end

  assign PipeEnable   = ctrl_q.pipe_en;
  assign PCHold       = ctrl_q.pc_hold;
  assign IFIDFlush    = ctrl_q.ifid_flush;
  assign cmd.CmdReady = ctrl_q.cmd_ready;
  assign State        = state;

  sat_counter #(
    .W (CNT_W)
  ) u_cycle_cnt (
    .clk   (ClockIn),
    .rst   (Reset),
    .en    (PipeEnable),
    .clr   (clear_fire),
    .count (CycleCount)
  );

endmodule

// File: tb/tb_mips_run_controller.sv
module tb_mips_run_controller;
  import mips_ctrl_pkg::*;

  localparam int S_IDLE = 0, S_RUN = 1, S_STEP = 2, S_DRAIN = 3, S_HALTED = 4;
  localparam int DRAIN = 4;

  logic clk = 1'b0;
  logic rst;
  logic halt;
  always #5 clk = ~clk;

  mips_run_controller_if #(.STEP_W(16)) ifa ();
  mips_run_controller_if #(.STEP_W(16)) ifb ();

  logic        pe_a, ph_a, fl_a, dr_a, dn_a;
  logic [31:0] cc_a;
  logic [2:0]  st_a;
  logic        pe_b, ph_b, fl_b, dr_b, dn_b;
  logic [3:0]  cc_b;
  logic [2:0]  st_b;

  mips_run_controller dut_a (
    .ClockIn(clk), .Reset(rst), .cmd(ifa), .HaltDetected(halt),
    .PipeEnable(pe_a), .PCHold(ph_a), .IFIDFlush(fl_a), .DatapathReset(dr_a),
    .CycleCount(cc_a), .Done(dn_a), .State(st_a)
  );

  mips_run_controller #(.CNT_W(4)) dut_b (
    .ClockIn(clk), .Reset(rst), .cmd(ifb), .HaltDetected(halt),
    .PipeEnable(pe_b), .PCHold(ph_b), .IFIDFlush(fl_b), .DatapathReset(dr_b),
    .CycleCount(cc_b), .Done(dn_b), .State(st_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural reference: "mode" plus a count of enabled cycles still owed
  // to the current STEP or drain burst; the executed-cycle total is kept
  // unbounded and clipped to each build's width only when compared.
  int     m_mode = S_IDLE;
  int     m_left = 0;
  longint m_cnt  = 0;
  bit     m_done = 0;
  bit     m_drst = 0;
  bit     m_ok   = 0;

  function automatic bit advancing(int mode);
    return (mode == S_RUN) || (mode == S_STEP) || (mode == S_DRAIN);
  endfunction

  task automatic model_edge(input bit v, input logic [1:0] op, input int sc, input bit h, input bit r);
    bit acc;
    if (r) begin
      m_mode = S_IDLE; m_left = 0; m_cnt = 0; m_done = 0; m_drst = 0; m_ok = 1;
      return;
    end
    acc = v && !(m_mode == S_STEP || m_mode == S_DRAIN);
    if (advancing(m_mode)) m_cnt++;
    m_done = 0;
    m_drst = 0;
    if ((m_mode == S_RUN || m_mode == S_STEP) && h) begin
      m_mode = S_DRAIN;
      m_left = DRAIN;
    end else if (m_mode == S_STEP || m_mode == S_DRAIN) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1;
        m_mode = (m_mode == S_STEP) ? S_IDLE : S_HALTED;
      end
    end else if (acc) begin
      if (m_mode == S_IDLE && op == CMD_RUN) m_mode = S_RUN;
      else if (m_mode == S_IDLE && op == CMD_STEP) begin
        m_mode = S_STEP;
        m_left = (sc == 0) ? 1 : sc;
      end else if (m_mode == S_RUN && op == CMD_STOP) m_mode = S_IDLE;
      else if ((m_mode == S_IDLE || m_mode == S_HALTED) && op == CMD_CLEAR) begin
        m_cnt  = 0;
        m_drst = 1;
        m_mode = S_IDLE;
      end
    end
  endtask

  task automatic compare_all();
    longint lim_a = 64'h0000_0000_FFFF_FFFF;
    check_val("state",      st_a, m_mode);
    check_val("state_b",    st_b, m_mode);
    check_val("pipe_en",    pe_a, advancing(m_mode));
    check_val("pc_hold",    ph_a, m_mode == S_DRAIN);
    check_val("ifid_flush", fl_a, m_mode == S_DRAIN);
    check_val("cmd_ready",  ifa.CmdReady, !(m_mode == S_STEP || m_mode == S_DRAIN));
    check_val("done",       dn_a, m_done);
    check_val("dp_reset",   dr_a, m_drst);
    check_val("cycles_a",   cc_a, (m_cnt > lim_a) ? lim_a : m_cnt);
    check_val("cycles_b",   cc_b, (m_cnt > 15) ? 15 : m_cnt);
  endtask

  // One clock: drive inputs now (just after a falling edge), let the rising
  // edge happen, advance the model, then compare on the next falling edge.
  task automatic tick(input bit v, input logic [1:0] op, input int sc, input bit h, input bit r);
    rst = r; halt = h;
    ifa.CmdValid = v; ifa.CmdOp = op; ifa.StepCount = 16'(sc);
    ifb.CmdValid = v; ifb.CmdOp = op; ifb.StepCount = 16'(sc);
    @(posedge clk);
    model_edge(v, op, sc, h, r);
    @(negedge clk);
    if (m_ok) compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, CMD_RUN, 0, 0, 0);
  endtask

  task automatic cmd(input logic [1:0] op, input int sc);
    tick(1, op, sc, 0, 0);
  endtask

  initial begin
    rst = 1; halt = 0;
    ifa.CmdValid = 0; ifa.CmdOp = 0; ifa.StepCount = 0;
    ifb.CmdValid = 0; ifb.CmdOp = 0; ifb.StepCount = 0;

    tick(0, CMD_RUN, 0, 0, 1);
    tick(0, CMD_RUN, 0, 0, 1);
    idle(1);
    check_val("rst_state", st_a, 0);
    check_val("rst_ready", ifa.CmdReady, 1);
    check_val("rst_cycles", cc_a, 0);

    // STEP 3, then STEP 0 (treated as 1)
    cmd(CMD_STEP, 3);
    check_val("step_ready_low", ifa.CmdReady, 0);
    idle(4);
    check_val("step3_cycles", cc_a, 3);
    cmd(CMD_STEP, 0);
    idle(3);
    check_val("step0_cycles", cc_a, 4);

    // RUN then STOP 11 edges later
    cmd(CMD_CLEAR, 0);
    idle(1);
    cmd(CMD_RUN, 0);
    idle(10);
    cmd(CMD_STOP, 0);
    idle(1);
    check_val("run_stop_cycles", cc_a, 11);
    check_val("run_stop_pe", pe_a, 0);

    // RUN, HALT on the 5th enabled cycle, drain, HALTED
    cmd(CMD_CLEAR, 0);
    idle(1);
    cmd(CMD_RUN, 0);
    idle(4);
    tick(0, CMD_RUN, 0, 1, 0);
    check_val("drain_hold", ph_a, 1);
    idle(5);
    check_val("halt_cycles", cc_a, 9);
    check_val("halt_state", st_a, 4);
    cmd(CMD_RUN, 0);
    check_val("halted_run_ignored", st_a, 4);
    cmd(CMD_CLEAR, 0);
    check_val("clear_dp_reset", dr_a, 1);
    check_val("clear_cycles", cc_a, 0);
    idle(1);
    check_val("clear_dp_pulse_end", dr_a, 0);
    cmd(CMD_RUN, 0);
    idle(1);
    check_val("resume_pe", pe_a, 1);
    cmd(CMD_STOP, 0);

    // STOP together with HALT in RUN: drain wins; then reset mid-drain
    cmd(CMD_RUN, 0);
    idle(2);
    tick(1, CMD_STOP, 0, 1, 0);
    check_val("stop_vs_halt", st_a, 3);
    idle(2);
    tick(0, CMD_RUN, 0, 0, 1);
    check_val("drain_abort_pe", pe_a, 0);
    check_val("drain_abort_ready", ifa.CmdReady, 1);
    idle(5);
    check_val("drain_abort_no_done", dn_a, 0);

    // long RUN saturates the 4-bit build
    cmd(CMD_RUN, 0);
    idle(20);
    check_val("sat_b", cc_b, 15);
    check_val("nosat_a", cc_a, 20);
    cmd(CMD_STOP, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
           $urandom_range(0, 6), $urandom_range(0, 24) == 0,
           $urandom_range(0, 299) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
